// File: rtl/ntt_rom_seq.sv
// Twiddle-ROM sequencer: streams 2^ADDR_W ROM words as dual-lane butterfly
// commands through a 2-entry skid FIFO with valid/ready backpressure.
module ntt_rom_seq #(
    parameter int ADDR_W = 7,
    parameter int Q      = 3329
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [63:0]       rom_dout,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [15:0]       cmd_zeta_a,
    output logic [7:0]        cmd_u_a,
    output logic [7:0]        cmd_v_a,
    output logic [15:0]       cmd_zeta_b,
    output logic [7:0]        cmd_u_b,
    output logic [7:0]        cmd_v_b
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [15:0]       LP_Q    = 16'(Q);
    localparam logic [ADDR_W-1:0] LP_LAST = '1;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_inflight;
    logic              r_err;
    logic [1:0]        r_count;
    logic [63:0]       r_head;
    logic [63:0]       r_tail;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_start;
    logic              w_last_pop;
    logic              w_bad;
    logic [2:0]        w_occ;
    logic [1:0]        w_wr_idx;

    assign cmd_valid = (r_count != 2'd0);
    assign w_pop     = cmd_valid & cmd_ready;
    assign w_push    = r_inflight;
    assign w_start   = (r_state == S_IDLE) && start;

    // Occupancy after this cycle's pop, counting the word still in flight
    assign w_occ = {1'b0, r_count} + {2'b00, r_inflight}
                 - {2'b00, w_pop};

    assign w_issue    = (r_state == S_FETCH) && (w_occ < 3'd2);
    assign w_last_pop = w_pop && (r_count == 2'd1) && !r_inflight;
    assign w_wr_idx   = r_count - {1'b0, w_pop};
    assign w_bad      = (rom_dout[63:48] >= LP_Q)
                     || (rom_dout[31:16] >= LP_Q);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (w_issue && r_addr == LP_LAST) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_last_pop) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= 2'd0;
            r_head     <= 64'd0;
            r_tail     <= 64'd0;
        end else begin
            r_inflight <= w_issue;
            if (w_start) begin
                r_addr <= '0;
                r_err  <= 1'b0;
            end else if (w_issue && r_addr != LP_LAST) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_pop) r_head <= r_tail;
            // Push lands after the shift, so a same-cycle pop+push keeps order
            if (w_push) begin
                if (w_wr_idx == 2'd0) r_head <= rom_dout;
                else                  r_tail <= rom_dout;
                if (w_bad) r_err <= 1'b1;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign rom_addr   = r_addr;
    assign err        = r_err;
    assign cmd_zeta_a = r_head[63:48];
    assign cmd_u_a    = r_head[47:40];
    assign cmd_v_a    = r_head[39:32];
    assign cmd_zeta_b = r_head[31:16];
    assign cmd_u_b    = r_head[15:8];
    assign cmd_v_b    = r_head[7:0];
endmodule

// File: tb/tb_ntt_rom_seq.sv
// Directed bench for ntt_rom_seq: model ROM, stream scoreboard against the
// ROM image, backpressure, random ready, start-while-busy, reset and err.
module tb_ntt_rom_seq;
    localparam logic [63:0] W0   = 64'h0c37_00_20_023d_00_08;
    localparam logic [63:0] W8   = 64'h0c37_08_28_07d4_10_18;
    localparam logic [63:0] W127 = 64'h072c_df_ff_06de_f7_ff;

    logic        clk;
    logic        srst;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  rom_addr;
    logic [63:0] rom_dout;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_zeta_a;
    logic [7:0]  cmd_u_a;
    logic [7:0]  cmd_v_a;
    logic [15:0] cmd_zeta_b;
    logic [7:0]  cmd_u_b;
    logic [7:0]  cmd_v_b;

    logic [63:0] rom [0:127];
    logic [63:0] got [0:127];
    logic [63:0] saved;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_idx;
    int n_cmds;
    int n_done;
    int done_t;
    int err_t;
    int t;
    logic err_at_done;

    ntt_rom_seq #(.ADDR_W(7), .Q(3329)) dut (
        .clk       (clk),
        .srst      (srst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_zeta_a(cmd_zeta_a),
        .cmd_u_a   (cmd_u_a),
        .cmd_v_a   (cmd_v_a),
        .cmd_zeta_b(cmd_zeta_b),
        .cmd_u_b   (cmd_u_b),
        .cmd_v_b   (cmd_v_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: word for the address sampled at an edge is valid next cycle
    always @(posedge clk) rom_dout <= rom[rom_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] head();
        return {cmd_zeta_a, cmd_u_a, cmd_v_a, cmd_zeta_b, cmd_u_b, cmd_v_b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_cycle(input logic rdy, input logic st);
        logic [63:0] w;
        cmd_ready = rdy;
        start     = st;
        w         = head();
        if (cmd_valid && rdy) begin
            if (exp_idx < 128) begin
                chk("stream", w, rom[exp_idx]);
                got[exp_idx] = w;
            end else begin
                chk("extra_cmd", 64'(exp_idx), 64'd127);
            end
            exp_idx++;
            n_cmds++;
        end
        if (done) begin
            n_done++;
            done_t      = t;
            err_at_done = err;
        end
        if (err && err_t < 0) err_t = t;
        @(posedge clk);
        @(negedge clk);
        t++;
        start = 1'b0;
    endtask

    task automatic start_run();
        exp_idx     = 0;
        n_cmds      = 0;
        n_done      = 0;
        done_t      = -1;
        err_t       = -1;
        err_at_done = 1'b0;
        cmd_ready   = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        t     = 1;
    endtask

    task automatic finish_run(input bit rnd, input int limit);
        while (n_done == 0 && t < limit)
            run_cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
        repeat (2) run_cycle(1'b1, 1'b0);
        chk("done_once", 64'(n_done), 64'd1);
        chk("n_cmds", 64'(n_cmds), 64'd128);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            rom[i] = {16'((i * 97 + 11) % 3329), 8'(i), 8'(i + 32),
                      16'((i * 53 + 700) % 3329), 8'(2 * i), 8'(2 * i + 1)};
        end
        rom[0]   = W0;
        rom[8]   = W8;
        rom[127] = W127;

        srst      = 1'b1;
        start     = 1'b0;
        cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_addr", 64'(rom_addr), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cmd", head(), 64'd0);
        srst = 1'b0;

        // Full run, ready always high
        start_run();
        chk("lat_c1_valid", 64'(cmd_valid), 64'd0);
        chk("lat_c1_busy", 64'(busy), 64'd1);
        run_cycle(1'b1, 1'b0);
        chk("lat_c2_valid", 64'(cmd_valid), 64'd0);
        run_cycle(1'b1, 1'b0);
        chk("lat_c3_valid", 64'(cmd_valid), 64'd1);
        chk("first_cmd", head(), W0);
        finish_run(1'b0, 400);
        chk("full_done_t", 64'(done_t), 64'd131);
        chk("full_no_err", 64'(err_t), 64'(-1));
        chk("full_last", got[127], W127);
        chk("full_idle", 64'(busy), 64'd0);

        // Backpressure: ready low for 10 cycles after 5 commands
        start_run();
        while (n_cmds < 5 && t < 50) run_cycle(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk("bp_addr", 64'(rom_addr), 64'd7);
            chk("bp_head", head(), rom[5]);
            run_cycle(1'b0, 1'b0);
        end
        finish_run(1'b0, 500);
        chk("bp_done_t", 64'(done_t), 64'd141);
        chk("bp_word8", got[8], W8);

        // Random 50% ready
        start_run();
        finish_run(1'b1, 2000);

        // start pulsed while busy at command 40
        start_run();
        while (n_done == 0 && t < 400) run_cycle(1'b1, 1'(n_cmds == 40));
        finish_run(1'b0, 400);
        chk("busy_start_done_t", 64'(done_t), 64'd131);
        chk("busy_start_idle", 64'(busy), 64'd0);

        // Reset mid-run at command 60
        start_run();
        while (n_cmds < 60 && t < 200) run_cycle(1'b1, 1'b0);
        srst      = 1'b1;
        cmd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        srst = 1'b0;
        chk("srst_valid", 64'(cmd_valid), 64'd0);
        chk("srst_busy", 64'(busy), 64'd0);
        chk("srst_addr", 64'(rom_addr), 64'd0);
        chk("srst_cmd", head(), 64'd0);
        start_run();
        finish_run(1'b0, 400);
        chk("replay_done_t", 64'(done_t), 64'd131);
        chk("replay_first", got[0], W0);

        // Out-of-range twiddle in word 5
        saved = rom[5];
        rom[5][31:16] = 16'h0d01;
        start_run();
        finish_run(1'b0, 400);
        chk("err_rise_t", 64'(err_t), 64'd8);
        chk("err_at_done", 64'(err_at_done), 64'd1);
        chk("err_sticky", 64'(err), 64'd1);
        chk("err_fwd", got[5], rom[5]);
        rom[5] = saved;
        start_run();
        chk("err_clear", 64'(err), 64'd0);
        finish_run(1'b0, 400);
        chk("err_clean_run", 64'(err_t), 64'(-1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
